// File: rtl/rom_access_arbiter_pkg.sv
// Shared constants for the ROM access arbiter and the ROM it fronts, so both
// agree on depth, widths and the access state encoding.
package rom_access_arbiter_pkg;

  localparam int ROM_DEPTH = 4096;
  localparam int ROM_AW    = 16;
  localparam int ROM_DW    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rom_access_arbiter_if.sv
// One requester's view of the ROM arbiter: request/grant with address, and a
// valid/ready response carrying data and an out-of-range flag.
interface rom_access_arbiter_if
  import rom_access_arbiter_pkg::*;
#(
  parameter int AW = ROM_AW,
  parameter int DW = ROM_DW
);

  logic          req;
  logic [AW-1:0] addr;
  logic          gnt;
  logic          rvalid;
  logic          rready;
  logic [DW-1:0] rdata;
  logic          err;

  modport master (output req, addr, rready, input gnt, rvalid, rdata, err);
  modport slave  (input req, addr, rready, output gnt, rvalid, rdata, err);

endinterface

// File: rtl/rom_access_arbiter_rr_arb2.sv
// Two-way round-robin grant logic, purely combinational; the caller owns the
// last-grant register and feeds it back through 'last'.
module rr_arb2 (
  input  logic       req0,
  input  logic       req1,
  input  logic       en,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       last_nxt
);

  always_comb begin
    // NOTE: every output of a combinational block gets a value before any
    // branch; otherwise the uncovered paths infer a latch.
    gnt = 2'b00;
    if (en) begin
      if (req0 && req1) gnt = last ? 2'b01 : 2'b10;
      else              gnt = {req1, req0};
    end
  end

  assign last_nxt = gnt[1] ? 1'b1 : (gnt[0] ? 1'b0 : last);

endmodule

// File: rtl/rom_access_arbiter.sv
// Shares one combinational ROM between instruction fetch (p0) and data load
// (p1): one access per grant, registered address and data, 2-cycle latency.
module rom_access_arbiter
  import rom_access_arbiter_pkg::*;
#(
  parameter int DEPTH = ROM_DEPTH,
  parameter int AW    = ROM_AW,
  parameter int DW    = ROM_DW
) (
  input  logic                      clk,
  input  logic                      rst_n,
  rom_access_arbiter_if.slave       p0,
  rom_access_arbiter_if.slave       p1,
  output logic [AW-1:0]             rom_addr,
  output logic                      rom_read,
  output logic                      rom_en,
  input  logic [DW-1:0]             rom_data,
  output logic                      busy
);

  state_t        state_q, state_d;
  logic          owner_q;
  logic          last_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;
  logic          err_q;

  logic          owner_rready;
  logic          grant_en;
  logic [1:0]    gnt;
  logic          gnt_any;
  logic          last_nxt;
  logic [AW-1:0] gnt_addr;
  logic          gnt_err;
  logic          rvalid0, rvalid1;

  assign owner_rready = owner_q ? p1.rready : p0.rready;

  // Qualified by rst_n so that gnt is also low while reset is held.
  assign grant_en = rst_n &&
                    ((state_q == IDLE) || ((state_q == RESP) && owner_rready));

  rr_arb2 u_arb (
    .req0     (p0.req),
    .req1     (p1.req),
    .en       (grant_en),
    .last     (last_q),
    .gnt      (gnt),
    .last_nxt (last_nxt)
  );

  assign gnt_any  = |gnt;
  assign gnt_addr = gnt[1] ? p1.addr : p0.addr;
  // Widened by one bit so the full-width unsigned compare cannot wrap.
  assign gnt_err  = {1'b0, gnt_addr} >= (AW + 1)'(DEPTH);

  assign p0.gnt = gnt[0];
  assign p1.gnt = gnt[1];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (gnt_any) state_d = READ;
      READ:    state_d = RESP;
      RESP:    if (owner_rready) state_d = gnt_any ? READ : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;  // "port 1 went last", so port 0 wins the first tie
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: registered state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      state_q <= state_d;
      if (gnt_any) begin
        owner_q <= gnt[1];
        last_q  <= last_nxt;
        addr_q  <= gnt_addr;
        err_q   <= gnt_err;
      end
      // Out-of-range reads never sample the bus, which may be floating.
      if (state_q == READ) data_q <= err_q ? '0 : rom_data;
    end
  end

  assign rom_addr = (state_q == READ) ? addr_q : '0;
  assign rom_en   = (state_q == READ) && !err_q;
  assign rom_read = rom_en;
  assign busy     = (state_q != IDLE);

  assign rvalid0   = (state_q == RESP) && !owner_q;
  assign rvalid1   = (state_q == RESP) &&  owner_q;
  assign p0.rvalid = rvalid0;
  assign p1.rvalid = rvalid1;
  assign p0.rdata  = rvalid0 ? data_q : '0;
  assign p1.rdata  = rvalid1 ? data_q : '0;
  assign p0.err    = rvalid0 && err_q;
  assign p1.err    = rvalid1 && err_q;

endmodule
